// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: digit type, 32-bit time layout offsets,
// digit limits and the run-state encoding.
package stopwatch_pkg;

    typedef logic [3:0] digit_t;

    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = 8;
    localparam int TIME_W     = DIGIT_W * NUM_DIGITS;

    // Layout: {hr_1,hr_0,min_1,min_0,sec_1,sec_0,cent_1,cent_0}
    localparam int CENT_0_LSB = 0;
    localparam int CENT_1_LSB = 4;
    localparam int SEC_0_LSB  = 8;
    localparam int SEC_1_LSB  = 12;
    localparam int MIN_0_LSB  = 16;
    localparam int MIN_1_LSB  = 20;
    localparam int HR_0_LSB   = 24;
    localparam int HR_1_LSB   = 28;

    localparam int DIGIT_LSB [NUM_DIGITS] = '{CENT_0_LSB, CENT_1_LSB, SEC_0_LSB, SEC_1_LSB,
                                              MIN_0_LSB, MIN_1_LSB, HR_0_LSB, HR_1_LSB};

    localparam digit_t LIMIT_TEN = 4'd9;
    localparam digit_t LIMIT_SIX = 4'd5;

    typedef logic [TIME_W-1:0] time_bcd_t;

    typedef enum logic {
        STOPPED = 1'b0,
        RUNNING = 1'b1
    } run_state_t;

    function automatic digit_t digit_limit(int lsb);
        if (lsb == SEC_1_LSB || lsb == MIN_1_LSB)
            return LIMIT_SIX;
        return LIMIT_TEN;
    endfunction

    function automatic digit_t saturate_digit(digit_t d, digit_t limit);
        return (d > limit) ? limit : d;
    endfunction

endpackage

// File: rtl/stopwatch_laps_if.sv
// Lap FIFO read port of the stopwatch; master is the lap consumer, slave is the stopwatch.
interface stopwatch_laps_if #(
    parameter int LAP_DEPTH = 4
);
    import stopwatch_pkg::*;

    logic                       lap_rd;
    time_bcd_t                  lap_bcd;
    logic                       lap_valid;
    logic                       lap_full;
    logic [$clog2(LAP_DEPTH):0] lap_count;

    modport master (
        output lap_rd,
        input  lap_bcd,
        input  lap_valid,
        input  lap_full,
        input  lap_count
    );

    modport slave (
        input  lap_rd,
        output lap_bcd,
        output lap_valid,
        output lap_full,
        output lap_count
    );

endinterface

// File: rtl/stopwatch_laps_bcd_digit.sv
// One BCD digit of the stopwatch, wrapping at LIMIT. With STOPWATCH_DOWN_EN defined it
// also supports a saturating parallel load and a borrow chain for counting down.
module bcd_digit
    import stopwatch_pkg::*;
#(
    parameter digit_t LIMIT = LIMIT_TEN
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   zero,
`ifdef STOPWATCH_DOWN_EN
    input  logic   ld,
    input  digit_t ld_val,
    input  logic   borrow_in,
    output logic   borrow_out,
`endif
    input  logic   carry_in,
    output logic   carry_out,
    output digit_t value
);

    // Zeroing wins over everything so that clear and hour wrap always land on 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            value <= '0;
        else if (zero)
            value <= '0;
`ifdef STOPWATCH_DOWN_EN
        else if (ld)
            value <= saturate_digit(ld_val, LIMIT);
`endif
        else if (carry_in)
            value <= (value == LIMIT) ? '0 : value + digit_t'(1);
`ifdef STOPWATCH_DOWN_EN
        else if (borrow_in)
            value <= (value == '0) ? LIMIT : value - digit_t'(1);
`endif
    end

    assign carry_out = carry_in && (value == LIMIT);

`ifdef STOPWATCH_DOWN_EN
    assign borrow_out = borrow_in && (value == '0);
`endif

endmodule

// File: rtl/stopwatch_laps.sv
// Centisecond BCD stopwatch with a lap FIFO. Define STOPWATCH_DOWN_EN to add the
// countdown mode (dir, load, load_bcd inputs and the done pulse).
module stopwatch_laps
    import stopwatch_pkg::*;
#(
    parameter int LAP_DEPTH = 4,
    parameter int HR_WRAP   = 100
) (
    input  logic      clk_milisec,
    input  logic      rst,
    input  logic      en,
    input  logic      start_stop,
    input  logic      clear,
    input  logic      split,
`ifdef STOPWATCH_DOWN_EN
    input  logic      dir,
    input  logic      load,
    input  time_bcd_t load_bcd,
    output logic      done,
`endif
    output time_bcd_t time_bcd,
    output logic      running,
    output logic      wrapped,
    output logic      lap_ovf,
    stopwatch_laps_if.slave lap
);

    localparam int PW = $clog2(LAP_DEPTH);
    localparam int CW = PW + 1;
    localparam int HR_0_IDX = HR_0_LSB / DIGIT_W;
    localparam digit_t HR_MAX_1 = digit_t'((HR_WRAP - 1) / 10);
    localparam digit_t HR_MAX_0 = digit_t'((HR_WRAP - 1) % 10);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    run_state_t state;
    time_bcd_t  time_q;
    logic       stopped;
    logic       clr_time;
    logic       count_up;
    logic       hr_wrap;

    assign stopped  = (state == STOPPED);
    assign running  = (state == RUNNING);
    assign clr_time = clear && stopped;
    assign time_bcd = time_q;

`ifdef STOPWATCH_DOWN_EN
    logic load_now;
    logic count_down;
    logic down_active;
    logic at_or_near_zero;
    logic done_pend;

    assign load_now        = load && stopped && !clear;
    assign down_active     = running && en && dir;
    assign count_down      = down_active && (time_q != '0);
    assign at_or_near_zero = (time_q <= time_bcd_t'(1));
    assign count_up        = running && en && !dir;
`else
    assign count_up        = running && en;
`endif

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        localparam bit IS_HOUR = (DIGIT_LSB[i] >= HR_0_LSB);
        logic cin;
        logic cout;
        logic zero;
`ifdef STOPWATCH_DOWN_EN
        logic bin;
        logic bout;
`endif

        if (i == 0) begin : g_lsd
            assign cin = count_up;
`ifdef STOPWATCH_DOWN_EN
            assign bin = count_down;
`endif
        end else begin : g_chain
            assign cin = g_digit[i-1].cout;
`ifdef STOPWATCH_DOWN_EN
            assign bin = g_digit[i-1].bout;
`endif
        end

        assign zero = clr_time || (IS_HOUR && hr_wrap);

        bcd_digit #(
            .LIMIT(digit_limit(DIGIT_LSB[i]))
        ) u_digit (
            .clk       (clk_milisec),
            .rst_n     (rst),
            .zero      (zero),
`ifdef STOPWATCH_DOWN_EN
            .ld        (load_now),
            .ld_val    (load_bcd[DIGIT_LSB[i] +: DIGIT_W]),
            .borrow_in (bin),
            .borrow_out(bout),
`endif
            .carry_in  (cin),
            .carry_out (cout),
            .value     (time_q[DIGIT_LSB[i] +: DIGIT_W])
        );
    end

    // Hours are two plain decimal digits, so the HR_WRAP modulus is enforced here.
    assign hr_wrap = g_digit[HR_0_IDX].cin
                  && (time_q[HR_1_LSB +: DIGIT_W] == HR_MAX_1)
                  && (time_q[HR_0_LSB +: DIGIT_W] == HR_MAX_0);

    time_bcd_t mem [LAP_DEPTH];
    ptr_t      wr_ptr;
    ptr_t      rd_ptr;
    cnt_t      lap_cnt;
    time_bcd_t head;
    logic      fifo_full;
    logic      do_wr;
    logic      do_rd;

    assign fifo_full = (lap_cnt == cnt_t'(LAP_DEPTH));
    assign do_rd     = lap.lap_rd && (lap_cnt != '0);
    assign do_wr     = split && (!fifo_full || lap.lap_rd);

    assign lap.lap_bcd   = head;
    assign lap.lap_valid = (lap_cnt != '0);
    assign lap.lap_full  = fifo_full;
    assign lap.lap_count = lap_cnt;

    always_ff @(posedge clk_milisec or negedge rst) begin
        if (!rst) begin
            state    <= STOPPED;
            wrapped  <= 1'b0;
            lap_ovf  <= 1'b0;
`ifdef STOPWATCH_DOWN_EN
            done     <= 1'b0;
            done_pend <= 1'b0;
`endif
        end else begin
            if (start_stop)
                state <= running ? STOPPED : RUNNING;
`ifdef STOPWATCH_DOWN_EN
            // Stop on the edge that reaches zero; done follows one cycle later.
            if (down_active && at_or_near_zero) begin
                state     <= STOPPED;
                done_pend <= 1'b1;
            end else begin
                done_pend <= 1'b0;
            end
            done <= done_pend;
`endif
            if (hr_wrap)
                wrapped <= 1'b1;
            else if (clr_time)
                wrapped <= 1'b0;

            if (split && fifo_full && !lap.lap_rd)
                lap_ovf <= 1'b1;
            else if (clr_time)
                lap_ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk_milisec) begin
        if (do_wr)
            mem[wr_ptr] <= time_q;
    end

    // The head register keeps the last popped value once the FIFO drains.
    always_ff @(posedge clk_milisec or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            lap_cnt <= '0;
            head    <= '0;
        end else begin
            if (do_wr)
                wr_ptr <= wr_ptr + ptr_t'(1);
            if (do_rd)
                rd_ptr <= rd_ptr + ptr_t'(1);

            if (do_wr && !do_rd)
                lap_cnt <= lap_cnt + cnt_t'(1);
            else if (!do_wr && do_rd)
                lap_cnt <= lap_cnt - cnt_t'(1);

            if (do_rd && (lap_cnt > cnt_t'(1)))
                head <= mem[rd_ptr + ptr_t'(1)];
            else if (do_wr && ((lap_cnt == '0) || (do_rd && (lap_cnt == cnt_t'(1)))))
                head <= time_q;
        end
    end

endmodule
